exynos4412_sequencer: RTL and testbench
=======================================

EXYNOS4412_SEQUENCER -- requirements
Module: exynos4412_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 8192: sysclk cycles per timebase tick, about 1.6 ms at the internal oscillator rate.
REQ-002 Parameter PWRON_TICKS, default 16: ticks from PMIC power-on to bootstrap.
REQ-003 Parameter SETUP_TICKS, default 4: ticks bootmode is driven before reset release.
REQ-004 Parameter HOLD_TICKS, default 2: ticks bootmode is held after reset release.
REQ-005 Parameter TIMEOUT_TICKS, default 64: maximum ticks to wait for cpu_resetout.
REQ-006 Parameter OFF_TICKS, default 8: ticks PMIC stays powered after reset assertion on shutdown.
REQ-007 Parameter BOOTMODE, default 6'b000101: strap value for cpu_bootmode.
REQ-008 Port sysclk, input, 1: the block's only clock, the free-running internal oscillator (3.3-5.5 MHz).
REQ-009 Port reset_INV, input, 1: asynchronous, active-low reset.
REQ-010 Port enable, input, 1: asynchronous CPU power request; high = on.
REQ-011 Port cpu_resetout, input, 1: asynchronous CPU reset-out; high = CPU out of reset.
REQ-012 Port cpu_pmic_pwron, output, 1: PMIC power-on; high = on.
REQ-013 Port cpu_pmic_reset_INV, output, 1: CPU/PMIC reset; active-low.
REQ-014 Port cpu_bank_en, output, 1: enables the CPU 1V8 I/O bank buffers.
REQ-015 Port cpu_bootmode, output, 6: strap value, valid only while bootmode_oe is high.
REQ-016 Port bootmode_oe, output, 1: high = drive cpu_bootmode; low = the top level tristates those pins.
REQ-017 Port fault, output, 1: high = boot timeout latched.
REQ-018 Port state, output, 3: current state encoding, for LED and debug.

Function
REQ-019 enable and cpu_resetout SHALL each pass through a 2-flop synchronizer; all logic below uses the synchronized versions (en_s, ro_s).
REQ-020 The prescaler SHALL count 0..TICK_DIV-1 and raise a 1-cycle tick when it equals TICK_DIV-1.
- The prescaler and tick counter SHALL clear on every state entry.
- Dwell of N ticks SHALL therefore equal exactly N*TICK_DIV cycles.
REQ-021 States and encodings SHALL be: OFF=0, PWRON=1, SETUP=2, HOLD=3, WAITRO=4, RUN=5, SHUTDOWN=6, FAULT=7.
REQ-022 In OFF, en_s=1 SHALL move the block to PWRON.
REQ-023 In PWRON, after PWRON_TICKS the block SHALL move to SETUP.
REQ-024 In SETUP, after SETUP_TICKS the block SHALL move to HOLD.
REQ-025 In HOLD, after HOLD_TICKS the block SHALL move to WAITRO.
REQ-026 In WAITRO:
- ro_s=1 SHALL move the block to RUN.
- TIMEOUT_TICKS elapsed without ro_s=1 SHALL move the block to FAULT.
- If ro_s=1 and the timeout coincide on the same cycle, RUN SHALL win.
REQ-027 In PWRON, SETUP, HOLD, WAITRO and RUN, en_s=0 SHALL move the block to SHUTDOWN; this takes priority over all other transitions.
REQ-028 In SHUTDOWN, after OFF_TICKS the block SHALL move to OFF; en_s is ignored until OFF is reached.
REQ-029 In FAULT, en_s=0 SHALL move the block to OFF.
REQ-030 Outputs SHALL be registered and SHALL update on the same edge as the state register, decoded from next state.
REQ-031 Output values per state (pwron, reset_INV, bank_en, bootmode_oe):
- OFF: 0,0,0,0
- PWRON: 1,0,0,0
- SETUP: 1,0,1,1
- HOLD: 1,1,1,1
- WAITRO: 1,1,1,0
- RUN: 1,1,1,0
- SHUTDOWN: 1,0,0,0
- FAULT: 0,0,0,0
REQ-032 cpu_bootmode SHALL equal BOOTMODE when bootmode_oe=1 and 6'b0 otherwise.
REQ-033 fault SHALL be 1 only in FAULT.
REQ-034 In RUN, a falling ro_s SHALL NOT change state; the CPU is permitted to self-reset.

Reset
REQ-035 While reset_INV=0, the block SHALL be in state OFF with all outputs 0 (cpu_pmic_reset_INV=0), prescaler, counter and synchronizers cleared.
REQ-036 After reset_INV deasserts, with enable held high, PWRON SHALL be entered on the 3rd sysclk edge.
REQ-037 Asserting reset_INV mid-sequence SHALL force OFF immediately, with no SHUTDOWN dwell.

Verification (TICK_DIV=4, PWRON=2, SETUP=2, HOLD=1, TIMEOUT=5, OFF=2)
REQ-038 Scenario "normal boot": enable high and cpu_resetout raised during WAITRO -> state 0,1,2,3,4,5 with dwells 8,8,4 cycles; bootmode_oe high for exactly 12 cycles; cpu_pmic_reset_INV rises 8 cycles after bootmode_oe.
REQ-039 Scenario "timeout": cpu_resetout held low -> FAULT after 20 cycles in WAITRO with fault=1 and pwron=0; enable dropped -> OFF and fault=0.
REQ-040 Scenario "abort": enable dropped during SETUP -> SHUTDOWN within 3 edges with bootmode_oe=0 and reset_INV=0; OFF after 8 cycles; enable pulses during SHUTDOWN ignored.
REQ-041 Scenario "tie": cpu_resetout rising on the timeout tick -> RUN, fault stays 0.
REQ-042 Scenario "reset": reset_INV pulsed in RUN -> all outputs 0 asynchronously; re-boot from PWRON after release.
REQ-043 Scenario "glitch": a 1-cycle enable pulse in OFF -> at most a PWRON entry followed by SHUTDOWN; no X on any output.

Source files
------------

// File: rtl/exynos4412_sequencer.sv
// Power/boot sequencer for an Exynos4412 CPU module: walks the PMIC power-on,
// bootmode strapping and reset release, watches cpu_resetout and handles shutdown.
module exynos4412_sequencer #(
  parameter int          TICK_DIV      = 8192,
  parameter int          PWRON_TICKS   = 16,
  parameter int          SETUP_TICKS   = 4,
  parameter int          HOLD_TICKS    = 2,
  parameter int          TIMEOUT_TICKS = 64,
  parameter int          OFF_TICKS     = 8,
  parameter logic [5:0]  BOOTMODE      = 6'b000101
) (
  input  logic       sysclk,
  input  logic       reset_INV,
  input  logic       enable,
  input  logic       cpu_resetout,
  output logic       cpu_pmic_pwron,
  output logic       cpu_pmic_reset_INV,
  output logic       cpu_bank_en,
  output logic [5:0] cpu_bootmode,
  output logic       bootmode_oe,
  output logic       fault,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_PWRON    = 3'd1,
    ST_SETUP    = 3'd2,
    ST_HOLD     = 3'd3,
    ST_WAITRO   = 3'd4,
    ST_RUN      = 3'd5,
    ST_SHUTDOWN = 3'd6,
    ST_FAULT    = 3'd7
  } state_t;

  localparam int            PW          = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST  = PW'(TICK_DIV - 1);
  localparam int            CW          = 16;
  localparam logic [CW-1:0] PWRON_LAST  = CW'(PWRON_TICKS - 1);
  localparam logic [CW-1:0] SETUP_LAST  = CW'(SETUP_TICKS - 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_TICKS - 1);
  localparam logic [CW-1:0] TMO_LAST    = CW'(TIMEOUT_TICKS - 1);
  localparam logic [CW-1:0] OFF_LAST    = CW'(OFF_TICKS - 1);

  logic          en_meta;
  logic          en_s;
  logic          ro_meta;
  logic          ro_s;
  state_t        state_q;
  state_t        state_d;
  logic [PW-1:0] presc;
  logic [CW-1:0] tcnt;
  logic          tick;
  logic          pwron_d;
  logic          rstn_d;
  logic          bank_d;
  logic          oe_d;

  // Both control inputs come from other power domains and are fully asynchronous.
  always_ff @(posedge sysclk or negedge reset_INV) begin
    if (!reset_INV) begin
      en_meta <= 1'b0;
      en_s    <= 1'b0;
      ro_meta <= 1'b0;
      ro_s    <= 1'b0;
    end else begin
      en_meta <= enable;
      en_s    <= en_meta;
      ro_meta <= cpu_resetout;
      ro_s    <= ro_meta;
    end
  end

  assign tick = (presc == PRESC_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OFF: begin
        if (en_s) state_d = ST_PWRON;
      end
      ST_PWRON: begin
        if (!en_s)                          state_d = ST_SHUTDOWN;
        else if (tick && tcnt == PWRON_LAST) state_d = ST_SETUP;
      end
      ST_SETUP: begin
        if (!en_s)                          state_d = ST_SHUTDOWN;
        else if (tick && tcnt == SETUP_LAST) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (!en_s)                         state_d = ST_SHUTDOWN;
        else if (tick && tcnt == HOLD_LAST) state_d = ST_WAITRO;
      end
      // A resetout arriving on the timeout tick still counts as a good boot.
      ST_WAITRO: begin
        if (!en_s)                        state_d = ST_SHUTDOWN;
        else if (ro_s)                    state_d = ST_RUN;
        else if (tick && tcnt == TMO_LAST) state_d = ST_FAULT;
      end
      ST_RUN: begin
        if (!en_s) state_d = ST_SHUTDOWN;
      end
      ST_SHUTDOWN: begin
        if (tick && tcnt == OFF_LAST) state_d = ST_OFF;
      end
      ST_FAULT: begin
        if (!en_s) state_d = ST_OFF;
      end
      default: state_d = ST_OFF;
    endcase
  end

  always_ff @(posedge sysclk or negedge reset_INV) begin
    if (!reset_INV) state_q <= ST_OFF;
    else            state_q <= state_d;
  end

  // Restarting the timebase on every state entry makes each dwell exact.
  always_ff @(posedge sysclk or negedge reset_INV) begin
    if (!reset_INV) begin
      presc <= '0;
      tcnt  <= '0;
    end else if (state_d != state_q) begin
      presc <= '0;
      tcnt  <= '0;
    end else if (tick) begin
      presc <= '0;
      tcnt  <= tcnt + CW'(1);
    end else begin
      presc <= presc + PW'(1);
    end
  end

  always_comb begin
    pwron_d = 1'b0;
    rstn_d  = 1'b0;
    bank_d  = 1'b0;
    oe_d    = 1'b0;
    case (state_d)
      ST_PWRON:    pwron_d = 1'b1;
      ST_SETUP: begin
        pwron_d = 1'b1;
        bank_d  = 1'b1;
        oe_d    = 1'b1;
      end
      ST_HOLD: begin
        pwron_d = 1'b1;
        rstn_d  = 1'b1;
        bank_d  = 1'b1;
        oe_d    = 1'b1;
      end
      ST_WAITRO, ST_RUN: begin
        pwron_d = 1'b1;
        rstn_d  = 1'b1;
        bank_d  = 1'b1;
      end
      ST_SHUTDOWN: pwron_d = 1'b1;
      default: ;
    endcase
  end

  // Outputs are decoded from the next state so they move on the same edge as state.
  always_ff @(posedge sysclk or negedge reset_INV) begin
    if (!reset_INV) begin
      cpu_pmic_pwron     <= 1'b0;
      cpu_pmic_reset_INV <= 1'b0;
      cpu_bank_en        <= 1'b0;
      bootmode_oe        <= 1'b0;
      cpu_bootmode       <= 6'b0;
      fault              <= 1'b0;
    end else begin
      cpu_pmic_pwron     <= pwron_d;
      cpu_pmic_reset_INV <= rstn_d;
      cpu_bank_en        <= bank_d;
      bootmode_oe        <= oe_d;
      cpu_bootmode       <= oe_d ? BOOTMODE : 6'b0;
      fault              <= (state_d == ST_FAULT);
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_exynos4412_sequencer.sv
// Self-checking bench for exynos4412_sequencer: directed boot scenarios plus a
// randomized enable/resetout phase, all compared against a dwell-timeline model.
module tb_exynos4412_sequencer;

  localparam int TD      = 4;
  localparam int PWR_T   = 2;
  localparam int SET_T   = 2;
  localparam int HLD_T   = 1;
  localparam int TMO_T   = 5;
  localparam int OFF_T   = 2;
  localparam logic [5:0] BM = 6'b000101;

  logic       sysclk = 1'b0;
  logic       reset_INV;
  logic       enable;
  logic       cpu_resetout;
  logic       cpu_pmic_pwron;
  logic       cpu_pmic_reset_INV;
  logic       cpu_bank_en;
  logic [5:0] cpu_bootmode;
  logic       bootmode_oe;
  logic       fault;
  logic [2:0] state;

  exynos4412_sequencer #(
    .TICK_DIV(TD), .PWRON_TICKS(PWR_T), .SETUP_TICKS(SET_T), .HOLD_TICKS(HLD_T),
    .TIMEOUT_TICKS(TMO_T), .OFF_TICKS(OFF_T), .BOOTMODE(BM)
  ) dut (
    .sysclk(sysclk), .reset_INV(reset_INV), .enable(enable), .cpu_resetout(cpu_resetout),
    .cpu_pmic_pwron(cpu_pmic_pwron), .cpu_pmic_reset_INV(cpu_pmic_reset_INV),
    .cpu_bank_en(cpu_bank_en), .cpu_bootmode(cpu_bootmode), .bootmode_oe(bootmode_oe),
    .fault(fault), .state(state)
  );

  always #5 sysclk = ~sysclk;

  int total = 0;
  int bad   = 0;

  // Reference: phase number plus cycles spent in it; inputs delayed two cycles.
  int m_state;
  int m_elapsed;
  bit m_en1, m_en_s, m_ro1, m_ro_s;

  int   cyc = 0;
  int   ent[8];
  int   oe_high, oe_rise, rst_rise;
  logic [2:0] prev_state;
  logic prev_oe, prev_rst;

  function automatic logic [3:0] m_outs(input int s);
    case (s)
      1:       return 4'b1000;
      2:       return 4'b1011;
      3:       return 4'b1111;
      4, 5:    return 4'b1110;
      6:       return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic model_reset();
    m_state = 0; m_elapsed = 0;
    m_en1 = 0; m_en_s = 0; m_ro1 = 0; m_ro_s = 0;
    prev_state = 3'd0; prev_oe = 1'b0; prev_rst = 1'b0;
  endtask

  task automatic model_edge();
    int nxt;
    nxt = m_state;
    if (m_state >= 1 && m_state <= 5 && !m_en_s) nxt = 6;
    else begin
      case (m_state)
        0: if (m_en_s) nxt = 1;
        1: if (m_elapsed + 1 == PWR_T * TD) nxt = 2;
        2: if (m_elapsed + 1 == SET_T * TD) nxt = 3;
        3: if (m_elapsed + 1 == HLD_T * TD) nxt = 4;
        4: if (m_ro_s) nxt = 5; else if (m_elapsed + 1 == TMO_T * TD) nxt = 7;
        6: if (m_elapsed + 1 == OFF_T * TD) nxt = 0;
        7: if (!m_en_s) nxt = 0;
        default: ;
      endcase
    end
    m_elapsed = (nxt != m_state) ? 0 : m_elapsed + 1;
    m_state   = nxt;
    m_en_s = m_en1; m_en1 = enable;
    m_ro_s = m_ro1; m_ro1 = cpu_resetout;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [3:0] e;
    e = m_outs(m_state);
    checkOutput("state", 32'(state), 32'(m_state));
    checkOutput("pwron", 32'(cpu_pmic_pwron), 32'(e[3]));
    checkOutput("reset_inv", 32'(cpu_pmic_reset_INV), 32'(e[2]));
    checkOutput("bank_en", 32'(cpu_bank_en), 32'(e[1]));
    checkOutput("bootmode_oe", 32'(bootmode_oe), 32'(e[0]));
    checkOutput("bootmode", 32'(cpu_bootmode), e[0] ? 32'(BM) : 32'd0);
    checkOutput("fault", 32'(fault), (m_state == 7) ? 32'd1 : 32'd0);
  endtask

  // One call = n clock edges with fixed inputs; called right after a falling edge.
  task automatic applyStimulus(input bit en, input bit ro, input int n);
    for (int i = 0; i < n; i++) begin
      enable = en;
      cpu_resetout = ro;
      @(posedge sysclk);
      model_edge();
      cyc++;
      #1;
      check_all();
      if (!$isunknown(state) && state != prev_state) ent[state] = cyc;
      if (bootmode_oe === 1'b1) oe_high++;
      if (bootmode_oe === 1'b1 && prev_oe === 1'b0) oe_rise = cyc;
      if (cpu_pmic_reset_INV === 1'b1 && prev_rst === 1'b0) rst_rise = cyc;
      prev_state = state;
      prev_oe    = bootmode_oe;
      prev_rst   = cpu_pmic_reset_INV;
      @(negedge sysclk);
    end
  endtask

  task automatic run_until(input int target, input bit en, input bit ro, input int max, input string tag);
    int k;
    k = 0;
    while (state !== 3'(target) && k < max) begin
      applyStimulus(en, ro, 1);
      k++;
    end
    checkOutput(tag, 32'(state), 32'(target));
  endtask

  initial begin
    int c0;
    bit en_r, ro_r;
    reset_INV = 1'b1;
    enable = 1'b0;
    cpu_resetout = 1'b0;
    model_reset();
    #2 reset_INV = 1'b0;
    @(negedge sysclk);
    $display("[TB] reset applied");
    checkOutput("rst_state", 32'(state), 32'd0);
    checkOutput("rst_pwron", 32'(cpu_pmic_pwron), 32'd0);
    checkOutput("rst_reset_inv", 32'(cpu_pmic_reset_INV), 32'd0);
    checkOutput("rst_oe", 32'(bootmode_oe), 32'd0);
    checkOutput("rst_bootmode", 32'(cpu_bootmode), 32'd0);

    // normal boot
    enable = 1'b1;
    reset_INV = 1'b1;
    oe_high = 0;
    applyStimulus(1, 0, 2);
    checkOutput("pre_pwron", 32'(state), 32'd0);
    applyStimulus(1, 0, 1);
    checkOutput("pwron_3rd_edge", 32'(state), 32'd1);
    run_until(4, 1, 0, 100, "reach_waitro");
    applyStimulus(1, 0, $urandom_range(0, 12));
    run_until(5, 1, 1, 40, "reach_run");
    checkOutput("pwron_dwell", 32'(ent[2] - ent[1]), 32'd8);
    checkOutput("setup_dwell", 32'(ent[3] - ent[2]), 32'd8);
    checkOutput("hold_dwell", 32'(ent[4] - ent[3]), 32'd4);
    checkOutput("oe_cycles", 32'(oe_high), 32'd12);
    checkOutput("rst_after_oe", 32'(rst_rise - oe_rise), 32'd8);
    applyStimulus(1, 0, 6);
    checkOutput("run_ro_fall", 32'(state), 32'd5);

    // asynchronous reset in RUN
    #2 reset_INV = 1'b0;
    #1;
    checkOutput("async_state", 32'(state), 32'd0);
    checkOutput("async_pwron", 32'(cpu_pmic_pwron), 32'd0);
    checkOutput("async_bank", 32'(cpu_bank_en), 32'd0);
    checkOutput("async_reset_inv", 32'(cpu_pmic_reset_INV), 32'd0);
    model_reset();
    @(negedge sysclk);
    @(negedge sysclk);
    reset_INV = 1'b1;
    applyStimulus(1, 1, 3);
    checkOutput("reboot_pwron", 32'(state), 32'd1);
    run_until(5, 1, 1, 100, "reboot_run");

    // orderly shutdown from RUN
    run_until(6, 0, 1, 5, "run_shutdown");
    run_until(0, 0, 1, 20, "shutdown_off");
    checkOutput("shutdown_dwell", 32'(ent[0] - ent[6]), 32'd8);

    // timeout
    run_until(4, 1, 0, 100, "tmo_waitro");
    run_until(7, 1, 0, 40, "tmo_fault");
    checkOutput("tmo_dwell", 32'(ent[7] - ent[4]), 32'd20);
    checkOutput("tmo_fault_flag", 32'(fault), 32'd1);
    checkOutput("tmo_pwron_off", 32'(cpu_pmic_pwron), 32'd0);
    applyStimulus(1, 0, 5);
    checkOutput("fault_sticky", 32'(state), 32'd7);
    run_until(0, 0, 0, 5, "fault_off");
    checkOutput("fault_cleared", 32'(fault), 32'd0);

    // resetout lands on the timeout tick
    run_until(4, 1, 0, 100, "tie_waitro");
    applyStimulus(1, 0, 17);
    applyStimulus(1, 1, 3);
    checkOutput("tie_run", 32'(state), 32'd5);
    checkOutput("tie_fault", 32'(fault), 32'd0);
    checkOutput("tie_dwell", 32'(ent[5] - ent[4]), 32'd20);
    run_until(0, 0, 0, 40, "tie_off");

    // abort during SETUP, enable pulses ignored in SHUTDOWN
    run_until(2, 1, 0, 100, "abort_setup");
    applyStimulus(1, 0, $urandom_range(0, 4));
    c0 = cyc;
    run_until(6, 0, 0, 3, "abort_shutdown");
    checkOutput("abort_latency", 32'(cyc - c0), 32'd3);
    checkOutput("abort_oe", 32'(bootmode_oe), 32'd0);
    checkOutput("abort_reset_inv", 32'(cpu_pmic_reset_INV), 32'd0);
    applyStimulus(0, 0, 1);
    applyStimulus(1, 0, 2);
    applyStimulus(0, 0, 1);
    run_until(0, 0, 0, 10, "abort_off");
    checkOutput("abort_dwell", 32'(ent[0] - ent[6]), 32'd8);
    applyStimulus(0, 0, 3);
    checkOutput("abort_stay_off", 32'(state), 32'd0);

    // one-cycle enable glitch in OFF
    applyStimulus(1, 0, 1);
    applyStimulus(0, 0, 14);
    checkOutput("glitch_off", 32'(state), 32'd0);
    checkOutput("glitch_no_x", 32'($isunknown({cpu_pmic_pwron, cpu_pmic_reset_INV, cpu_bank_en,
                cpu_bootmode, bootmode_oe, fault, state})), 32'd0);

    // randomized enable / resetout activity
    en_r = 1'b0;
    ro_r = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 24) == 0) en_r = ~en_r;
      if ($urandom_range(0, 9) == 0) ro_r = 1'($urandom_range(0, 1));
      applyStimulus(en_r, ro_r, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
